midi_parameter_control: RTL and testbench
=========================================

// Module: midi_parameter_control
// PURPOSE
//  Byte-serial MIDI front end plus synth-parameter register file. Parses raw MIDI bytes (from UART RX)
//  into channel messages, then latches Control Change values for seven synth parameters and flags
//  each update. Sits between the MIDI UART and the voice/envelope/mixer blocks.
// PARAMETERS
//  CC_TEMPO    7'd20  CC number driving parameters.tempo
//  CC_UNISON   7'd21  CC number driving parameters.unison
//  CC_ATTACK   7'd73  CC number driving parameters.attack
//  CC_DECAY    7'd75  CC number driving parameters.decay
//  CC_SUSTAIN  7'd79  CC number driving parameters.sustain
//  CC_RELEASE  7'd72  CC number driving parameters.release
//  CC_VOLUME   7'd7   CC number driving parameters.volume
// PORTS
//  clock_50_000_000  in   1   sole clock, all state on rising edge
//  reset_l           in   1   asynchronous, active-HIGH reset (asserted when 1, despite the suffix)
//  data_in           in   8   raw MIDI byte
//  data_in_ready     in   1   data_in valid this cycle; one byte per high cycle, no backpressure
//  message           out  22  {type[3:0], channel[3:0], data1[6:0], data2[6:0]}
//  message_ready     out  1   one-cycle pulse, message valid
//  parameters        out  49  {tempo,unison,attack,decay,sustain,release,volume}, 7 bits each, MSB=tempo
//  parameter_changes out  7   per-field update pulse, same order (bit6=tempo ... bit0=volume)
// BEHAVIOUR
//  Reset: parser IDLE, running status cleared, message=0, message_ready=0, parameter_changes=0,
//   parameters = tempo 64, unison 0, attack 0, decay 0, sustain 127, release 0, volume 100.
//  Types: NOTE_OFF 4'h8, NOTE_ON 4'h9, POLY_AT 4'hA, CONTROL_CHANGE 4'hB, PROGRAM 4'hC,
//   CHAN_AT 4'hD, PITCH_BEND 4'hE. Bytes are examined only when data_in_ready=1.
//  Parser FSM: IDLE -> DATA1 -> DATA2 (two-data types) or IDLE -> DATA1 (C/D types).
//   - Status byte 8x-Ex (bit7=1) in any state: store type/channel as running status, goto DATA1,
//     discard any partial message.
//   - Status F0-F7: clear running status, goto IDLE; SysEx data bytes ignored until next status.
//   - Real-time F8-FF: ignored entirely, FSM state and running status unchanged.
//   - Data byte (bit7=0) in DATA1: latch data1; 2-byte types goto DATA2; C/D types complete (data2=0).
//   - Data byte in DATA2: latch data2, complete, return to DATA1 (running status).
//   - Data byte in IDLE with no running status: ignored.
//  Completion: on the edge that accepts the final byte, message is registered and message_ready
//   is high for exactly the following cycle. message holds its value until the next completion.
//  NOTE_ON with velocity 0 is passed through unchanged (consumers treat it as note-off).
//  Parameter update: when message_ready=1, type=CONTROL_CHANGE (any channel) and data1 equals a
//   CC_* number, the matching field <= data2 on the next edge and its parameter_changes bit is
//   high for exactly that one following cycle; all other bits 0. Unmatched CC and non-CC
//   messages: no change, no pulse. Rewriting an identical value still pulses.
//  Latency: final byte accepted at edge N -> message_ready high cycle N..N+1 -> parameters updated
//   and change bit high cycle N+1..N+2.
//  Reset mid-message: partial message dropped, parameters return to reset values immediately.
//  Multiple CC_* parameters set to the same number: all matching fields update and pulse together.
// TESTING
//  B0,14,0A -> message {B,0,20,10}, one message_ready pulse; tempo=10, parameter_changes=7'b1000000 one cycle.
//  90,0A,50 then 80,1E,00 -> two message_ready pulses {9,0,10,80},{8,0,30,0}; parameters/changes unchanged.
//  B0 then CCs 21/73/75/79/72/7 with values 20/30/40/50/60/70 (full 3-byte each) -> each field set, single
//   matching change bit per message; final parameters {10,20,30,40,50,60,70}.
//  Running status: B0,07,46,15,05 -> volume=70 then unison=5, two pulses; F8 inserted mid-message ignored.
//  B0,10,33 (unmapped CC) and C0,05 -> message_ready pulses (C0: data1=5,data2=0) but no parameter change.
//  Assert reset_l after B0,14 (before value) -> no message; all outputs at reset values; next B0,14,0A works.

Source files
------------

// File: rtl/midi_parameter_control.sv
// rtl/midi_parameter_control.sv - MIDI byte parser and CC-driven synth parameter register file
module midi_parameter_control #(
    parameter logic [6:0] CC_TEMPO   = 7'd20,
    parameter logic [6:0] CC_UNISON  = 7'd21,
    parameter logic [6:0] CC_ATTACK  = 7'd73,
    parameter logic [6:0] CC_DECAY   = 7'd75,
    parameter logic [6:0] CC_SUSTAIN = 7'd79,
    parameter logic [6:0] CC_RELEASE = 7'd72,
    parameter logic [6:0] CC_VOLUME  = 7'd7
) (
    input  logic        clock_50_000_000,
    input  logic        reset_l,
    input  logic [7:0]  data_in,
    input  logic        data_in_ready,
    output logic [21:0] message,
    output logic        message_ready,
    output logic [48:0] parameters,
    output logic [6:0]  parameter_changes
);

    localparam logic [3:0] TYPE_CONTROL_CHANGE = 4'hB;
    localparam logic [3:0] TYPE_PROGRAM        = 4'hC;
    localparam logic [3:0] TYPE_CHAN_AT        = 4'hD;

    // Field order matches the packed output: tempo in the top slice, volume in the bottom.
    localparam logic [48:0] PARAM_RESET = {7'd64, 7'd0, 7'd0, 7'd0, 7'd127, 7'd0, 7'd100};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA1,
        ST_DATA2
    } parse_state_t;

    parse_state_t state, state_next;

    // Running status: the last channel status byte seen, reused for data-only messages.
    logic        rs_valid, rs_valid_next;
    logic [3:0]  rs_type, rs_type_next;
    logic [3:0]  rs_chan, rs_chan_next;
    logic [6:0]  data1, data1_next;
    logic        complete;
    logic [21:0] message_next;
    logic        one_data_type;
    logic        is_cc;
    logic [6:0]  cc_match;

    // Parser state, running status and first data byte registers.
    always_ff @(posedge clock_50_000_000 or posedge reset_l) begin
        if (reset_l) begin
            state    <= ST_IDLE;
            rs_valid <= 1'b0;
            rs_type  <= 4'h0;
            rs_chan  <= 4'h0;
            data1    <= 7'd0;
        end else begin
            state    <= state_next;
            rs_valid <= rs_valid_next;
            rs_type  <= rs_type_next;
            rs_chan  <= rs_chan_next;
            data1    <= data1_next;
        end
    end

    // Next-state decode: status bytes reset framing, data bytes advance it.
    always_comb begin
        state_next    = state;
        rs_valid_next = rs_valid;
        rs_type_next  = rs_type;
        rs_chan_next  = rs_chan;
        data1_next    = data1;
        complete      = 1'b0;
        message_next  = message;
        one_data_type = (rs_type == TYPE_PROGRAM) || (rs_type == TYPE_CHAN_AT);

        if (data_in_ready) begin
            if (data_in[7]) begin
                if (data_in[7:4] != 4'hF) begin
                    // Channel status: becomes running status, any partial message is dropped.
                    rs_valid_next = 1'b1;
                    rs_type_next  = data_in[7:4];
                    rs_chan_next  = data_in[3:0];
                    state_next    = ST_DATA1;
                end else if (!data_in[3]) begin
                    // System common / SysEx: cancels running status; its data is ignored in IDLE.
                    rs_valid_next = 1'b0;
                    state_next    = ST_IDLE;
                end
                // Real-time bytes (F8-FF) fall through untouched so they can interleave anywhere.
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_next = ST_IDLE;
                    end
                    ST_DATA1: begin
                        if (rs_valid) begin
                            if (one_data_type) begin
                                complete     = 1'b1;
                                message_next = {rs_type, rs_chan, data_in[6:0], 7'd0};
                                state_next   = ST_DATA1;
                            end else begin
                                data1_next = data_in[6:0];
                                state_next = ST_DATA2;
                            end
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    ST_DATA2: begin
                        if (rs_valid) begin
                            complete     = 1'b1;
                            message_next = {rs_type, rs_chan, data1, data_in[6:0]};
                            state_next   = ST_DATA1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Completed message register and its one-cycle valid pulse.
    always_ff @(posedge clock_50_000_000 or posedge reset_l) begin
        if (reset_l) begin
            message       <= 22'd0;
            message_ready <= 1'b0;
        end else begin
            message       <= message_next;
            message_ready <= complete;
        end
    end

    // Which parameter slots the current CC number addresses; several may share a number.
    always_comb begin
        is_cc       = message_ready && (message[21:18] == TYPE_CONTROL_CHANGE);
        cc_match[6] = (message[13:7] == CC_TEMPO);
        cc_match[5] = (message[13:7] == CC_UNISON);
        cc_match[4] = (message[13:7] == CC_ATTACK);
        cc_match[3] = (message[13:7] == CC_DECAY);
        cc_match[2] = (message[13:7] == CC_SUSTAIN);
        cc_match[1] = (message[13:7] == CC_RELEASE);
        cc_match[0] = (message[13:7] == CC_VOLUME);
    end

    // Parameter file: matched fields take data2, each update pulses its change bit for one cycle.
    always_ff @(posedge clock_50_000_000 or posedge reset_l) begin
        if (reset_l) begin
            parameters        <= PARAM_RESET;
            parameter_changes <= 7'd0;
        end else begin
            parameter_changes <= is_cc ? cc_match : 7'd0;
            for (int i = 0; i < 7; i++) begin
                if (is_cc && cc_match[i]) begin
                    parameters[i*7 +: 7] <= message[6:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parameter_control.sv
// tb/tb_midi_parameter_control.sv - scoreboard bench for midi_parameter_control
module tb_midi_parameter_control;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_in_ready;
    logic [21:0] message;
    logic        message_ready;
    logic [48:0] parameters;
    logic [6:0]  parameter_changes;

    localparam logic [48:0] P_RESET = {7'd64, 7'd0, 7'd0, 7'd0, 7'd127, 7'd0, 7'd100};

    int n_vec = 0;
    int n_err = 0;

    logic [21:0] sb[$];
    logic [48:0] m_params;
    logic [6:0]  m_chg;
    logic        pend;
    logic [21:0] e;
    logic [6:0]  cc_tab[7];

    midi_parameter_control dut (
        .clock_50_000_000  (clk),
        .reset_l           (rst),
        .data_in           (data_in),
        .data_in_ready     (data_in_ready),
        .message           (message),
        .message_ready     (message_ready),
        .parameters        (parameters),
        .parameter_changes (parameter_changes)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        data_in       = b;
        data_in_ready = 1'b1;
        @(posedge clk);
        #1;
        data_in_ready = 1'b0;
        data_in       = 8'h00;
    endtask

    task automatic exp_msg(input logic [3:0] t, input logic [3:0] c, input logic [6:0] d1, input logic [6:0] d2);
        sb.push_back({t, c, d1, d2});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each message and checks the parameter file one cycle later.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend) begin
                check("params", parameters, m_params);
                check("changes", parameter_changes, m_chg);
                pend = 1'b0;
            end else begin
                check("changes_quiet", parameter_changes, 7'd0);
            end
            if (message_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_msg", message, 22'h3fffff);
                end else begin
                    e = sb.pop_front();
                    check("message", message, e);
                    m_chg = 7'd0;
                    if (e[21:18] == 4'hB) begin
                        for (int i = 0; i < 7; i++) begin
                            if (e[13:7] == cc_tab[i]) begin
                                m_params[i*7 +: 7] = e[6:0];
                                m_chg[i] = 1'b1;
                            end
                        end
                    end
                    pend = 1'b1;
                end
            end
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        cc_tab[6] = 7'd20; cc_tab[5] = 7'd21; cc_tab[4] = 7'd73; cc_tab[3] = 7'd75;
        cc_tab[2] = 7'd79; cc_tab[1] = 7'd72; cc_tab[0] = 7'd7;
        m_params      = P_RESET;
        m_chg         = 7'd0;
        pend          = 1'b0;
        rst           = 1'b1;
        data_in       = 8'h00;
        data_in_ready = 1'b0;
        idle(3);
        check("rst_message", message, 22'd0);
        check("rst_ready", message_ready, 1'b0);
        check("rst_params", parameters, P_RESET);
        check("rst_changes", parameter_changes, 7'd0);
        rst = 1'b0;
        idle(2);

        // Tempo CC
        send(8'hB0); send(8'h14); exp_msg(4'hB, 4'h0, 7'd20, 7'd10); send(8'h0A);
        idle(4);

        // Note on / note off: messages only
        send(8'h90); send(8'h0A); exp_msg(4'h9, 4'h0, 7'd10, 7'd80); send(8'h50);
        send(8'h80); send(8'h1E); exp_msg(4'h8, 4'h0, 7'd30, 7'd0); send(8'h00);
        idle(4);

        // Remaining mapped CCs, full three-byte messages
        send(8'hB0); send(8'h15); exp_msg(4'hB, 4'h0, 7'd21, 7'd20); send(8'h14); idle(2);
        send(8'hB0); send(8'h49); exp_msg(4'hB, 4'h0, 7'd73, 7'd30); send(8'h1E); idle(2);
        send(8'hB0); send(8'h4B); exp_msg(4'hB, 4'h0, 7'd75, 7'd40); send(8'h28); idle(2);
        send(8'hB0); send(8'h4F); exp_msg(4'hB, 4'h0, 7'd79, 7'd50); send(8'h32); idle(2);
        send(8'hB0); send(8'h48); exp_msg(4'hB, 4'h0, 7'd72, 7'd60); send(8'h3C); idle(2);
        send(8'hB0); send(8'h07); exp_msg(4'hB, 4'h0, 7'd7, 7'd70); send(8'h46);
        idle(4);
        check("final_params", parameters, {7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70});

        // Running status with interleaved real-time bytes, channel 3
        send(8'hB3); send(8'h07); send(8'hF8); exp_msg(4'hB, 4'h3, 7'd7, 7'd70); send(8'h46);
        send(8'h15); send(8'hF8); exp_msg(4'hB, 4'h3, 7'd21, 7'd5); send(8'h05);
        idle(4);

        // Unmapped CC, program change with running status
        send(8'hB0); send(8'h10); exp_msg(4'hB, 4'h0, 7'd16, 7'd51); send(8'h33);
        send(8'hC0); exp_msg(4'hC, 4'h0, 7'd5, 7'd0); send(8'h05);
        exp_msg(4'hC, 4'h0, 7'd6, 7'd0); send(8'h06);
        idle(4);

        // SysEx cancels running status; data after it is ignored
        send(8'hF0); send(8'h05); send(8'h07); send(8'hF7); send(8'h14); send(8'h0A);
        idle(4);

        // Status byte mid-message drops the partial; identical rewrite still pulses
        send(8'h90); send(8'h0A); send(8'hB0); send(8'h14); exp_msg(4'hB, 4'h0, 7'd20, 7'd11); send(8'h0B);
        idle(2);
        send(8'hB0); send(8'h14); exp_msg(4'hB, 4'h0, 7'd20, 7'd11); send(8'h0B);
        idle(4);

        // Reset mid-message
        send(8'hB0); send(8'h14);
        rst      = 1'b1;
        m_params = P_RESET;
        #1;
        check("midrst_message", message, 22'd0);
        check("midrst_ready", message_ready, 1'b0);
        check("midrst_params", parameters, P_RESET);
        check("midrst_changes", parameter_changes, 7'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h0A);
        idle(3);
        check("post_rst_params", parameters, P_RESET);
        send(8'hB0); send(8'h14); exp_msg(4'hB, 4'h0, 7'd20, 7'd10); send(8'h0A);
        idle(5);
        check("post_rst_tempo", parameters[48:42], 7'd10);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
